mdio_phy_sequencer: RTL and testbench



---
 rtl/mdio_seq_pkg.sv | 46 ++++
 rtl/mdio_req_timer.sv | 28 ++
 rtl/mdio_phy_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_mdio_phy_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_seq_pkg.sv
// rtl/mdio_seq_pkg.sv - Shared state type, init table and MDIO constants for the PHY sequencer
package mdio_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_ACK,
    S_WR_WAIT,
    S_NEXT,
    S_GAP,
    S_RD_REQ,
    S_RD_ACK,
    S_RD_WAIT,
    S_ERROR
  } state_t;

  localparam int TBL_LEN  = 3;
  localparam int IDX_W    = 2;
  localparam int PHY_W    = 3;
  localparam int TMR_W    = 16;
  localparam int LINK_BIT = 2;
  localparam logic [4:0] BMSR_ADDR = 5'h1;

  // Init table register: BMCR, ANAR, BMCR
  function automatic logic [4:0] tbl_reg(input logic [IDX_W-1:0] idx);
    logic [4:0] r;
    case (idx)
      2'd1:    r = 5'h4;
      default: r = 5'h0;
    endcase
    return r;
  endfunction

  // Init table data: aneg enable/100M/FD, advertise 10/100 FD/HD, restart aneg
  function automatic logic [15:0] tbl_data(input logic [IDX_W-1:0] idx);
    logic [15:0] d;
    case (idx)
      2'd0:    d = 16'h3100;
      2'd1:    d = 16'h01E1;
      2'd2:    d = 16'h3300;
      default: d = 16'h0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdio_req_timer.sv
// rtl/mdio_req_timer.sv - Loadable down-counter shared by the ack timeout and the poll gap
module mdio_req_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Load wins over counting; the counter parks at zero once expired
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mdio_phy_sequencer.sv
// rtl/mdio_phy_sequencer.sv - Writes the PHY init table then round-robin polls link state over MDIO
module mdio_phy_sequencer
  import mdio_seq_pkg::*;
#(
  parameter int NUM_PHY  = 2,
  parameter int PHY_BASE = 0,
  parameter int POLL_GAP = 1000,
  parameter int ACK_TO   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               busy,
  input  logic [15:0]        rd_data,
  input  logic               rd_valid,
  output logic [4:0]         phy_add_o,
  output logic [4:0]         reg_add,
  output logic [15:0]        wr_data,
  output logic               wren,
  output logic               rden,
  output logic               cfg_done,
  output logic [NUM_PHY-1:0] link_up,
  output logic               err
);

  localparam logic [PHY_W-1:0] LAST_PHY  = PHY_W'(NUM_PHY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TBL_LEN - 1);
  localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_TO - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(POLL_GAP - 1);
  localparam logic [4:0]       BASE_ADDR = 5'(PHY_BASE);

  state_t             state, state_n;
  logic [PHY_W-1:0]   phy, phy_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [4:0]         phy_add_n, reg_add_n;
  logic [15:0]        wr_data_n;
  logic               wren_n, rden_n, cfg_done_n, err_n;
  logic [NUM_PHY-1:0] link_up_n;
  logic               tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]   tmr_val;

  // Only the link bit of BMSR is of interest
  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_data[15:LINK_BIT+1], rd_data[LINK_BIT-1:0]};

  mdio_req_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // State and registered outputs; request strobes default low so they last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phy       <= '0;
      idx       <= '0;
      phy_add_o <= '0;
      reg_add   <= '0;
      wr_data   <= '0;
      wren      <= 1'b0;
      rden      <= 1'b0;
      cfg_done  <= 1'b0;
      link_up   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      phy       <= phy_n;
      idx       <= idx_n;
      phy_add_o <= phy_add_n;
      reg_add   <= reg_add_n;
      wr_data   <= wr_data_n;
      wren      <= wren_n;
      rden      <= rden_n;
      cfg_done  <= cfg_done_n;
      link_up   <= link_up_n;
      err       <= err_n;
    end
  end

  // Next-state, counters and output values
  always_comb begin
    state_n    = state;
    phy_n      = phy;
    idx_n      = idx;
    phy_add_n  = phy_add_o;
    reg_add_n  = reg_add;
    wr_data_n  = wr_data;
    wren_n     = 1'b0;
    rden_n     = 1'b0;
    cfg_done_n = cfg_done;
    link_up_n  = link_up;
    err_n      = err;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = '0;

    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_n    = S_WR_REQ;
          phy_n      = '0;
          idx_n      = '0;
          cfg_done_n = 1'b0;
          err_n      = 1'b0;
          link_up_n  = '0;
        end
      end

      S_WR_REQ: begin
        if (!busy) begin
          wren_n    = 1'b1;
          phy_add_n = BASE_ADDR + 5'(phy);
          reg_add_n = tbl_reg(idx);
          wr_data_n = tbl_data(idx);
          tmr_load  = 1'b1;
          tmr_val   = ACK_LOAD;
          state_n   = S_WR_ACK;
        end
      end

      S_WR_ACK: begin
        if (busy) begin
          state_n = S_WR_WAIT;
        end else if (tmr_expired) begin
          err_n   = 1'b1;
          state_n = S_ERROR;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_WR_WAIT: begin
        if (!busy) begin
          state_n = S_NEXT;
        end
      end

      S_NEXT: begin
        if (idx == LAST_IDX) begin
          idx_n = '0;
          if (phy == LAST_PHY) begin
            cfg_done_n = 1'b1;
            phy_n      = '0;
            tmr_load   = 1'b1;
            tmr_val    = GAP_LOAD;
            state_n    = S_GAP;
          end else begin
            phy_n   = phy + 1'b1;
            state_n = S_WR_REQ;
          end
        end else begin
          idx_n   = idx + 1'b1;
          state_n = S_WR_REQ;
        end
      end

      S_GAP: begin
        if (tmr_expired) begin
          state_n = S_RD_REQ;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_RD_REQ: begin
        if (!busy) begin
          rden_n    = 1'b1;
          phy_add_n = BASE_ADDR + 5'(phy);
          reg_add_n = BMSR_ADDR;
          tmr_load  = 1'b1;
          tmr_val   = ACK_LOAD;
          state_n   = S_RD_ACK;
        end
      end

      S_RD_ACK: begin
        if (busy) begin
          state_n = S_RD_WAIT;
        end else if (tmr_expired) begin
          err_n   = 1'b1;
          state_n = S_ERROR;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_RD_WAIT: begin
        if (rd_valid) begin
          for (int n = 0; n < NUM_PHY; n++) begin
            if (phy == PHY_W'(n)) begin
              link_up_n[n] = rd_data[LINK_BIT];
            end
          end
        end
        if (!busy) begin
          phy_n    = (phy == LAST_PHY) ? '0 : phy + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_n  = S_GAP;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_phy_sequencer.sv
// tb/tb_mdio_phy_sequencer.sv - Self-checking bench for the MDIO PHY sequencer
module tb_mdio_phy_sequencer;

  localparam int NUM_PHY  = 2;
  localparam int PHY_BASE = 0;
  localparam int POLL_GAP = 20;
  localparam int ACK_TO   = 16;
  localparam int TBL_N    = 3;
  localparam int WR_TOTAL = NUM_PHY * TBL_N;
  localparam int BUSY_LEN = 10;

  localparam logic [4:0]  EXP_REG [TBL_N] = '{5'h0, 5'h4, 5'h0};
  localparam logic [15:0] EXP_DAT [TBL_N] = '{16'h3100, 16'h01E1, 16'h3300};

  typedef struct {
    bit          is_rd;
    bit          both;
    bit          during_busy;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] d;
    int          cyc;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               ext_busy = 1'b0;
  logic               mdl_busy = 1'b0;
  logic               busy;
  logic [15:0]        rd_data = '0;
  logic               rd_valid = 1'b0;
  logic [4:0]         phy_add_o;
  logic [4:0]         reg_add;
  logic [15:0]        wr_data;
  logic               wren;
  logic               rden;
  logic               cfg_done;
  logic [NUM_PHY-1:0] link_up;
  logic               err;

  assign busy = mdl_busy | ext_busy;

  ev_t         log_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          start_cyc = 0;
  int          drop_write = -1;
  bit          rand_mode = 1'b0;
  int          clear_req = 0;
  int          clear_ack = 0;
  logic [15:0] resp [NUM_PHY] = '{16'h0000, 16'h0004};

  // Slave model state
  bit                 pend = 1'b0;
  bit                 cur_rd = 1'b0;
  int                 cur_phy = 0;
  int                 bcnt = 0;
  int                 blen = 0;
  int                 wr_seen = 0;
  int                 rd_done = 0;
  logic [NUM_PHY-1:0] exp_link = '0;

  mdio_phy_sequencer #(
    .NUM_PHY  (NUM_PHY),
    .PHY_BASE (PHY_BASE),
    .POLL_GAP (POLL_GAP),
    .ACK_TO   (ACK_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .phy_add_o (phy_add_o),
    .reg_add   (reg_add),
    .wr_data   (wr_data),
    .wren      (wren),
    .rden      (rden),
    .cfg_done  (cfg_done),
    .link_up   (link_up),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Request logger followed by the MDIO master model: busy one cycle after a request, rd_valid as busy drops
  always @(negedge clk) begin
    ev_t e;
    if (wren || rden) begin
      e.is_rd       = rden;
      e.both        = wren && rden;
      e.during_busy = busy;
      e.pa          = phy_add_o;
      e.ra          = reg_add;
      e.d           = wr_data;
      e.cyc         = cyc;
      log_q.push_back(e);
    end
    rd_valid = 1'b0;
    if (clear_ack != clear_req) begin
      clear_ack = clear_req;
      mdl_busy  = 1'b0;
      pend      = 1'b0;
      bcnt      = 0;
      wr_seen   = 0;
      rd_done   = 0;
      exp_link  = '0;
      rd_data   = '0;
    end else begin
      if (pend) begin
        pend     = 1'b0;
        mdl_busy = 1'b1;
        bcnt     = blen;
      end else if (bcnt > 0) begin
        bcnt = bcnt - 1;
        if (bcnt == 0) begin
          mdl_busy = 1'b0;
          if (cur_rd && cur_phy < NUM_PHY) begin
            rd_data  = rand_mode ? 16'($urandom) : resp[cur_phy];
            rd_valid = 1'b1;
            exp_link[cur_phy] = rd_data[2];
            rd_done  = rd_done + 1;
          end
        end
      end
      if (wren && !rden) begin
        if (wr_seen != drop_write) begin
          pend   = 1'b1;
          cur_rd = 1'b0;
          blen   = rand_mode ? int'($urandom_range(50, 1)) : BUSY_LEN;
        end
        wr_seen = wr_seen + 1;
      end else if (rden && !wren) begin
        pend    = 1'b1;
        cur_rd  = 1'b1;
        cur_phy = int'(5'(phy_add_o - 5'(PHY_BASE)));
        blen    = rand_mode ? int'($urandom_range(50, 1)) : BUSY_LEN;
      end
    end
  end

  // Reference: k-th write of a configuration pass, returned as {phy_addr, reg, data}
  function automatic logic [25:0] exp_write(input int k);
    int p;
    int i;
    logic [4:0] pa;
    p  = k / TBL_N;
    i  = k % TBL_N;
    pa = 5'((PHY_BASE + p) % 32);
    return {pa, EXP_REG[i], EXP_DAT[i]};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b1;
    ext_busy   = 1'b0;
    drop_write = -1;
    rand_mode  = 1'b0;
    clear_req  = clear_req + 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++; if (wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %b exp 0", wren); end
    vectors++; if (rden !== 1'b0) begin miscompares++; $display("FAIL reset_rden got %b exp 0", rden); end
    vectors++; if (phy_add_o !== 5'h0) begin miscompares++; $display("FAIL reset_phy_add got %h exp 00", phy_add_o); end
    vectors++; if (reg_add !== 5'h0) begin miscompares++; $display("FAIL reset_reg_add got %h exp 00", reg_add); end
    vectors++; if (wr_data !== 16'h0) begin miscompares++; $display("FAIL reset_wr_data got %h exp 0000", wr_data); end
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_done got %b exp 0", cfg_done); end
    vectors++; if (link_up !== '0) begin miscompares++; $display("FAIL reset_link_up got %b exp 0", link_up); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_config();
    int base;
    int n;
    reset_dut();
    base = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() <= base && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (log_q.size() <= base) begin
      miscompares++; $display("FAIL cfg_first_wren got none exp wren within 50 cycles");
    end else if (log_q[base].cyc - start_cyc != 2) begin
      miscompares++; $display("FAIL cfg_latency got %0d exp 2", log_q[base].cyc - start_cyc);
    end
    n = 0;
    while (log_q.size() < base + 3 && n < 200) begin @(negedge clk); n++; end
    pulse_start();
    n = 0;
    while (cfg_done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    vectors++; if (cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg_done got %b exp 1", cfg_done); end
    vectors++; if (log_q.size() - base != WR_TOTAL) begin miscompares++; $display("FAIL cfg_write_count got %0d exp %0d", log_q.size() - base, WR_TOTAL); end
    for (int k = 0; k < WR_TOTAL && base + k < log_q.size(); k++) begin
      vectors++;
      if (log_q[base+k].is_rd || {log_q[base+k].pa, log_q[base+k].ra, log_q[base+k].d} !== exp_write(k)) begin
        miscompares++;
        $display("FAIL cfg_write_%0d got rd=%b %h/%h/%h exp wr %h", k, log_q[base+k].is_rd,
                 log_q[base+k].pa, log_q[base+k].ra, log_q[base+k].d, exp_write(k));
      end
    end
  endtask

  task automatic test_poll();
    int base;
    int n;
    int sp;
    logic [NUM_PHY-1:0] exp_lu;
    base = log_q.size();
    n = 0;
    while (log_q.size() < base + 5 && n < 1000) begin @(negedge clk); n++; end
    vectors++; if (log_q.size() < base + 5) begin miscompares++; $display("FAIL poll_count got %0d exp 5", log_q.size() - base); end
    for (int j = 0; j < 5 && base + j < log_q.size(); j++) begin
      vectors++;
      if (!log_q[base+j].is_rd || log_q[base+j].pa !== 5'((PHY_BASE + j % NUM_PHY) % 32) || log_q[base+j].ra !== 5'h1) begin
        miscompares++;
        $display("FAIL poll_read_%0d got rd=%b pa=%h ra=%h exp rd=1 pa=%h ra=01", j, log_q[base+j].is_rd,
                 log_q[base+j].pa, log_q[base+j].ra, 5'((PHY_BASE + j % NUM_PHY) % 32));
      end
      if (j > 0) begin
        sp = log_q[base+j].cyc - log_q[base+j-1].cyc;
        vectors++;
        if (sp < POLL_GAP + BUSY_LEN + 1 || sp > POLL_GAP + BUSY_LEN + 5) begin
          miscompares++; $display("FAIL poll_spacing_%0d got %0d exp %0d..%0d", j, sp, POLL_GAP + BUSY_LEN + 1, POLL_GAP + BUSY_LEN + 5);
        end
      end
    end
    exp_lu = '0;
    for (int p = 0; p < NUM_PHY; p++) exp_lu[p] = resp[p][2];
    vectors++; if (link_up !== exp_lu) begin miscompares++; $display("FAIL poll_link_up got %b exp %b", link_up, exp_lu); end
    vectors++; if (cfg_done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL poll_flags got cfg_done=%b err=%b exp 1 0", cfg_done, err); end
  endtask

  task automatic test_timeout();
    int base;
    int n;
    int w;
    int sz;
    reset_dut();
    drop_write = 1;
    base = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() < base + 2 && n < 200) begin @(negedge clk); n++; end
    w = (log_q.size() >= base + 2) ? log_q[base+1].cyc : cyc;
    n = 0;
    while (err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL timeout_err got %b exp 1", err);
    end else if (cyc - w != ACK_TO) begin
      miscompares++; $display("FAIL timeout_delay got %0d exp %0d", cyc - w, ACK_TO);
    end
    sz = log_q.size();
    repeat (60) @(negedge clk);
    vectors++; if (log_q.size() != sz) begin miscompares++; $display("FAIL timeout_quiet got %0d requests exp 0", log_q.size() - sz); end
    vectors++; if (err !== 1'b1 || cfg_done !== 1'b0) begin miscompares++; $display("FAIL timeout_hold got err=%b cfg_done=%b exp 1 0", err, cfg_done); end
    drop_write = -1;
    sz = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() <= sz && n < 50) begin @(negedge clk); n++; end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL restart_err got %b exp 0", err); end
    vectors++;
    if (log_q.size() <= sz) begin
      miscompares++; $display("FAIL restart_wren got none exp write");
    end else if ({log_q[sz].pa, log_q[sz].ra, log_q[sz].d} !== exp_write(0) || log_q[sz].cyc - start_cyc != 2) begin
      miscompares++; $display("FAIL restart_first got %h/%h/%h lat=%0d exp %h lat=2", log_q[sz].pa, log_q[sz].ra,
                              log_q[sz].d, log_q[sz].cyc - start_cyc, exp_write(0));
    end
  endtask

  task automatic test_ext_busy();
    int base;
    int n;
    int rel;
    reset_dut();
    @(negedge clk);
    ext_busy = 1'b1;
    base = log_q.size();
    pulse_start();
    repeat (10) @(negedge clk);
    vectors++; if (log_q.size() != base) begin miscompares++; $display("FAIL ext_busy_withheld got %0d requests exp 0", log_q.size() - base); end
    ext_busy = 1'b0;
    rel = cyc;
    n = 0;
    while (log_q.size() <= base && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (log_q.size() <= base) begin
      miscompares++; $display("FAIL ext_busy_wren got none exp write");
    end else if (log_q[base].cyc != rel + 1 || {log_q[base].pa, log_q[base].ra, log_q[base].d} !== exp_write(0)) begin
      miscompares++; $display("FAIL ext_busy_wren got cyc+%0d %h/%h/%h exp cyc+1 %h", log_q[base].cyc - rel,
                              log_q[base].pa, log_q[base].ra, log_q[base].d, exp_write(0));
    end
  endtask

  task automatic test_rst_mid();
    int base;
    int n;
    reset_dut();
    base = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() < base + 2 && n < 200) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (wren !== 1'b0 || rden !== 1'b0 || phy_add_o !== 5'h0 || reg_add !== 5'h0 || wr_data !== 16'h0 ||
        cfg_done !== 1'b0 || link_up !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got wren=%b rden=%b pa=%h ra=%h wd=%h cd=%b lu=%b err=%b exp all 0",
               wren, rden, phy_add_o, reg_add, wr_data, cfg_done, link_up, err);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    base = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() <= base && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (log_q.size() <= base) begin
      miscompares++; $display("FAIL rst_mid_restart got none exp write");
    end else if ({log_q[base].pa, log_q[base].ra, log_q[base].d} !== exp_write(0)) begin
      miscompares++; $display("FAIL rst_mid_restart got %h/%h/%h exp %h", log_q[base].pa, log_q[base].ra, log_q[base].d, exp_write(0));
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    int rd_i;
    reset_dut();
    rand_mode = 1'b1;
    base = log_q.size();
    pulse_start();
    n = 0;
    while (rd_done < 8 && n < 12000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    vectors++; if (rd_done < 8) begin miscompares++; $display("FAIL rand_progress got %0d reads exp 8", rd_done); end
    rd_i = 0;
    for (int k = base; k < log_q.size(); k++) begin
      vectors++;
      if (log_q[k].both || log_q[k].during_busy) begin
        miscompares++; $display("FAIL rand_protocol_%0d got both=%b busy=%b exp 0 0", k - base, log_q[k].both, log_q[k].during_busy);
      end
      vectors++;
      if (k - base < WR_TOTAL) begin
        if (log_q[k].is_rd || {log_q[k].pa, log_q[k].ra, log_q[k].d} !== exp_write(k - base)) begin
          miscompares++; $display("FAIL rand_write_%0d got rd=%b %h/%h/%h exp %h", k - base, log_q[k].is_rd,
                                  log_q[k].pa, log_q[k].ra, log_q[k].d, exp_write(k - base));
        end
      end else begin
        if (!log_q[k].is_rd || log_q[k].pa !== 5'((PHY_BASE + rd_i % NUM_PHY) % 32) || log_q[k].ra !== 5'h1) begin
          miscompares++; $display("FAIL rand_read_%0d got rd=%b pa=%h ra=%h exp pa=%h ra=01", rd_i, log_q[k].is_rd,
                                  log_q[k].pa, log_q[k].ra, 5'((PHY_BASE + rd_i % NUM_PHY) % 32));
        end
        rd_i++;
      end
    end
    vectors++; if (link_up !== exp_link) begin miscompares++; $display("FAIL rand_link_up got %b exp %b", link_up, exp_link); end
    vectors++; if (cfg_done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL rand_flags got cfg_done=%b err=%b exp 1 0", cfg_done, err); end
    rand_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_poll();
    test_timeout();
    test_ext_busy();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
